com_op_code_sequencer: RTL and testbench
========================================

Name: com_op_code_sequencer

Overview:
- Command front-end that sits directly upstream of the test-number decoder.
- Accepts one-cycle command writes from the AXI-lite register bank and produces op_code_w_reset, op_code_w_execute and test_number with the timing the decoder needs.
- Keeps execute asserted until the selected test engine reports done, the command is aborted, or a watchdog timeout fires.
- Exposes busy state, sticky status flags and a command counter for software readback.

Parameters:
- RESET_CYCLES, 4: width of the op_code_w_reset pulse in clk cycles; must be 1 to 255.
- TIMEOUT_W, 24: width of the watchdog counter.
- TIMEOUT_CYCLES, 1000000: EXEC watchdog limit in clk cycles; 0 disables the watchdog.
- MAX_TEST, 5: highest legal test number; the legal range is 1..MAX_TEST.

Ports:
- clk  in  1  block clock (S_AXI_ACLK or pl_clk1)
- reset_n  in  1  asynchronous active-low reset
- cmd_wr  in  1  one-cycle command write strobe
- cmd_word  in  8  [3:0] op field, [7:4] test field
- test_done  in  1  done indication from the active test engine, sampled only in EXEC
- op_code_w_reset  out  1  registered reset level to the decoder
- op_code_w_execute  out  1  registered execute level to the decoder
- test_number  out  4  latched test number
- busy  out  1  high when state is not IDLE
- state  out  2  IDLE=0, RST=1, EXEC=2
- done_sticky  out  1  last EXEC ended by test_done
- err_illegal  out  1  sticky: undefined op, or EXECUTE with an out-of-range test
- err_busy  out  1  sticky: command rejected because the block was busy
- err_timeout  out  1  sticky: watchdog expired
- aborted  out  1  sticky: EXEC ended by ABORT
- cmd_count  out  8  count of accepted commands, wraps 255->0

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs and counters go to 0 and the state goes to IDLE. Deassertion is sampled on clk.
- Latency: every output is registered. A command accepted on edge n takes effect on outputs after edge n.
- Op codes:
  - 0x0 NOP
  - 0x1 RESET
  - 0x2 EXECUTE
  - 0x3 ABORT
  - 0x4 CLEAR_STATUS
  - 0x5..0xF are illegal.
- IDLE with cmd_wr=1:
  - NOP: no effect and not counted.
  - RESET: go to RST, drive op_code_w_reset=1, set test_number=0, clear all sticky flags.
  - EXECUTE with test field in 1..MAX_TEST: latch test_number, go to EXEC, drive op_code_w_execute=1, clear the watchdog.
  - EXECUTE with test field 0 or above MAX_TEST: set err_illegal, stay in IDLE, do not count.
  - ABORT: no effect, but counted.
  - CLEAR_STATUS: clear all sticky flags, counted.
  - 0x5..0xF: set err_illegal, not counted.
- RST:
  - op_code_w_reset stays high for exactly RESET_CYCLES cycles, then drops and the state returns to IDLE.
  - Any cmd_wr other than NOP is rejected: set err_busy, not counted.
- EXEC:
  - op_code_w_execute stays high and test_number is held stable.
  - The watchdog increments every cycle.
  - test_done=1: next edge drives execute=0, sets done_sticky and goes to IDLE.
  - Watchdog reaches TIMEOUT_CYCLES (when nonzero): execute=0, set err_timeout, go to IDLE.
  - cmd_wr ABORT: execute=0, set aborted, go to IDLE, counted.
  - cmd_wr RESET: execute=0 on the same edge that op_code_w_reset=1, go to RST, counted. op_code_w_reset and op_code_w_execute are never high together.
  - Any other cmd_wr except NOP: set err_busy, ignored.
- Simultaneous events in EXEC, in priority order (highest first): RESET command, then test_done, then ABORT command, then timeout.
  - test_done together with ABORT: done_sticky is set, aborted is not.
  - test_done together with timeout: no err_timeout.
- test_done outside EXEC is ignored.
- test_number keeps its value after EXEC ends. Only a RESET command or reset_n changes it back to 0.
- After any EXEC exit, execute is low for at least one cycle before it can be raised again. This guarantees the decoder sees a fresh rising edge.
- reset_n asserted mid-RST or mid-EXEC drops both op outputs immediately.

Test Plan:
- Reset, then cmd_wr with cmd_word=0x32 (EXECUTE, test 3). Required: execute=1 and test_number=3 one cycle later, busy=1, state=2. Pulse test_done 20 cycles later; required: execute=0 next cycle, done_sticky=1, cmd_count=1.
- cmd_word=0x01 (RESET) with RESET_CYCLES=4. Required: op_code_w_reset high for exactly 4 cycles, test_number=0. A cmd_word=0x12 written during RST is rejected: err_busy=1, no execute, cmd_count unchanged.
- cmd_word=0x62 and cmd_word=0x02 (tests 6 and 0). Required: err_illegal=1, state stays 0, execute never rises. Then cmd_word=0x04 clears err_illegal.
- TIMEOUT_CYCLES=100, EXECUTE test 5 with no test_done. Required: execute falls after 100 cycles, err_timeout=1. A second run with test_done asserted on the expiry cycle: done_sticky=1 and err_timeout=0.
- During EXEC, assert cmd_wr=0x03 together with test_done. Required: done_sticky=1 and aborted=0. Separately, RESET issued during EXEC: execute falls on the same edge reset rises, no cycle has both high.
- Issue 256 accepted ABORT commands in IDLE. Required: cmd_count wraps to 0. Drop reset_n mid-EXEC: all outputs 0 immediately.

Source files
------------

// File: rtl/com_op_code_sequencer.sv
// Command front-end for the test-number decoder: turns one-cycle command writes into
// registered reset/execute levels, with watchdog, sticky status and a command counter.
module com_op_code_sequencer #(
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_W      = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_TEST       = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_word,
    input  logic       test_done,
    output logic       op_code_w_reset,
    output logic       op_code_w_execute,
    output logic [3:0] test_number,
    output logic       busy,
    output logic [1:0] state,
    output logic       done_sticky,
    output logic       err_illegal,
    output logic       err_busy,
    output logic       err_timeout,
    output logic       aborted,
    output logic [7:0] cmd_count
);

    typedef enum logic [1:0] {StIdle = 2'd0, StRst = 2'd1, StExec = 2'd2} state_e;

    localparam logic [3:0] OpNop   = 4'h0;
    localparam logic [3:0] OpRst   = 4'h1;
    localparam logic [3:0] OpExec  = 4'h2;
    localparam logic [3:0] OpAbort = 4'h3;
    localparam logic [3:0] OpClr   = 4'h4;

    localparam logic [7:0]           RstLoad    = 8'(RESET_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TimeoutLim = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] WdOne      = TIMEOUT_W'(1);
    localparam bit                   WdEnable   = (TIMEOUT_CYCLES != 0);

    state_e                 r_state, w_state_d;
    logic [7:0]             r_rst_cnt, w_rst_cnt_d;
    logic [TIMEOUT_W-1:0]   r_wd, w_wd_d;
    logic [3:0]             r_test, w_test_d;
    logic                   r_done, w_done_d;
    logic                   r_ill, w_ill_d;
    logic                   r_ebusy, w_ebusy_d;
    logic                   r_eto, w_eto_d;
    logic                   r_abort, w_abort_d;
    logic [7:0]             r_cnt, w_cnt_d;
    logic                   r_rst_out, r_exec_out;

    logic [3:0] w_op;
    logic [3:0] w_tf;
    logic       w_tf_ok;
    logic       w_clr;

    assign w_op    = cmd_word[3:0];
    assign w_tf    = cmd_word[7:4];
    assign w_tf_ok = (w_tf != 4'd0) && (32'(w_tf) <= MAX_TEST);

    always_comb begin
        w_state_d   = r_state;
        w_rst_cnt_d = r_rst_cnt;
        w_wd_d      = r_wd;
        w_test_d    = r_test;
        w_done_d    = r_done;
        w_ill_d     = r_ill;
        w_ebusy_d   = r_ebusy;
        w_eto_d     = r_eto;
        w_abort_d   = r_abort;
        w_cnt_d     = r_cnt;
        w_clr       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (cmd_wr) begin
                    case (w_op)
                        OpNop: ;
                        OpRst: begin
                            w_state_d   = StRst;
                            w_rst_cnt_d = RstLoad;
                            w_test_d    = 4'd0;
                            w_clr       = 1'b1;
                            w_cnt_d     = r_cnt + 8'd1;
                        end
                        OpExec: begin
                            if (w_tf_ok) begin
                                w_state_d = StExec;
                                w_test_d  = w_tf;
                                w_wd_d    = '0;
                                w_cnt_d   = r_cnt + 8'd1;
                            end else begin
                                w_ill_d = 1'b1;
                            end
                        end
                        OpAbort: w_cnt_d = r_cnt + 8'd1;
                        OpClr: begin
                            w_clr   = 1'b1;
                            w_cnt_d = r_cnt + 8'd1;
                        end
                        default: w_ill_d = 1'b1;
                    endcase
                end
            end
            StRst: begin
                if (cmd_wr && (w_op != OpNop)) w_ebusy_d = 1'b1;
                if (r_rst_cnt == 8'd0) begin
                    w_state_d = StIdle;
                end else begin
                    w_rst_cnt_d = r_rst_cnt - 8'd1;
                end
            end
            StExec: begin
                w_wd_d = r_wd + WdOne;
                if (cmd_wr && (w_op == OpRst)) begin
                    w_state_d   = StRst;
                    w_rst_cnt_d = RstLoad;
                    w_test_d    = 4'd0;
                    w_clr       = 1'b1;
                    w_cnt_d     = r_cnt + 8'd1;
                end else begin
                    if (cmd_wr && (w_op != OpNop) && (w_op != OpAbort)) w_ebusy_d = 1'b1;
                    if (cmd_wr && (w_op == OpAbort)) w_cnt_d = r_cnt + 8'd1;
                    // Exit priority below RESET: done, then abort, then watchdog.
                    if (test_done) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end else if (cmd_wr && (w_op == OpAbort)) begin
                        w_state_d = StIdle;
                        w_abort_d = 1'b1;
                        w_done_d  = 1'b0;
                    end else if (WdEnable && (w_wd_d == TimeoutLim)) begin
                        w_state_d = StIdle;
                        w_eto_d   = 1'b1;
                        w_done_d  = 1'b0;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_clr) begin
            w_done_d  = 1'b0;
            w_ill_d   = 1'b0;
            w_ebusy_d = 1'b0;
            w_eto_d   = 1'b0;
            w_abort_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_rst_cnt  <= 8'd0;
            r_wd       <= '0;
            r_test     <= 4'd0;
            r_done     <= 1'b0;
            r_ill      <= 1'b0;
            r_ebusy    <= 1'b0;
            r_eto      <= 1'b0;
            r_abort    <= 1'b0;
            r_cnt      <= 8'd0;
            r_rst_out  <= 1'b0;
            r_exec_out <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_rst_cnt  <= w_rst_cnt_d;
            r_wd       <= w_wd_d;
            r_test     <= w_test_d;
            r_done     <= w_done_d;
            r_ill      <= w_ill_d;
            r_ebusy    <= w_ebusy_d;
            r_eto      <= w_eto_d;
            r_abort    <= w_abort_d;
            r_cnt      <= w_cnt_d;
            r_rst_out  <= (w_state_d == StRst);
            r_exec_out <= (w_state_d == StExec);
        end
    end

    assign op_code_w_reset   = r_rst_out;
    assign op_code_w_execute = r_exec_out;
    assign test_number       = r_test;
    assign busy              = (r_state != StIdle);
    assign state             = r_state;
    assign done_sticky       = r_done;
    assign err_illegal       = r_ill;
    assign err_busy          = r_ebusy;
    assign err_timeout       = r_eto;
    assign aborted           = r_abort;
    assign cmd_count         = r_cnt;

endmodule

// File: tb/tb_com_op_code_sequencer.sv
// Bench for com_op_code_sequencer: directed scenarios plus randomized commands, all
// checked against a command-level reference model.
module tb_com_op_code_sequencer;

    localparam int RC  = 4;
    localparam int TO  = 100;
    localparam int MXT = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_word = 8'h00;
    logic       test_done = 1'b0;
    logic       op_code_w_reset, op_code_w_execute, busy;
    logic [3:0] test_number;
    logic [1:0] state;
    logic       done_sticky, err_illegal, err_busy, err_timeout, aborted;
    logic [7:0] cmd_count;

    com_op_code_sequencer #(
        .RESET_CYCLES  (RC),
        .TIMEOUT_W     (24),
        .TIMEOUT_CYCLES(TO),
        .MAX_TEST      (MXT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_wr           (cmd_wr),
        .cmd_word         (cmd_word),
        .test_done        (test_done),
        .op_code_w_reset  (op_code_w_reset),
        .op_code_w_execute(op_code_w_execute),
        .test_number      (test_number),
        .busy             (busy),
        .state            (state),
        .done_sticky      (done_sticky),
        .err_illegal      (err_illegal),
        .err_busy         (err_busy),
        .err_timeout      (err_timeout),
        .aborted          (aborted),
        .cmd_count        (cmd_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int overlap = 0;

    always @(negedge clk) if (op_code_w_reset && op_code_w_execute) overlap++;

    // Reference model: mode 0 idle, 1 reset pulse, 2 executing.
    int m_mode, m_rst_left, m_age, m_tn, m_cnt;
    bit m_done, m_ill, m_ebusy, m_eto, m_abort;

    task automatic model_clear_flags();
        m_done = 0; m_ill = 0; m_ebusy = 0; m_eto = 0; m_abort = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_rst_left = 0; m_age = 0; m_tn = 0; m_cnt = 0;
        model_clear_flags();
    endtask

    task automatic model_start_reset();
        m_mode = 1; m_rst_left = RC; m_tn = 0;
        model_clear_flags();
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic model_step(input bit wr, input logic [7:0] w, input bit d);
        int op = int'(w[3:0]);
        int tf = int'(w[7:4]);
        if (m_mode == 0) begin
            if (wr) begin
                if (op == 1) model_start_reset();
                else if (op == 2) begin
                    if (tf >= 1 && tf <= MXT) begin
                        m_mode = 2; m_age = 0; m_tn = tf; m_cnt = (m_cnt + 1) % 256;
                    end else m_ill = 1;
                end else if (op == 3) m_cnt = (m_cnt + 1) % 256;
                else if (op == 4) begin model_clear_flags(); m_cnt = (m_cnt + 1) % 256; end
                else if (op != 0) m_ill = 1;
            end
        end else if (m_mode == 1) begin
            if (wr && op != 0) m_ebusy = 1;
            m_rst_left--;
            if (m_rst_left == 0) m_mode = 0;
        end else begin
            m_age++;
            if (wr && op == 1) model_start_reset();
            else begin
                if (wr && op != 0 && op != 3) m_ebusy = 1;
                if (wr && op == 3) m_cnt = (m_cnt + 1) % 256;
                if (d) begin m_mode = 0; m_done = 1; end
                else if (wr && op == 3) begin m_mode = 0; m_abort = 1; m_done = 0; end
                else if (m_age == TO) begin m_mode = 0; m_eto = 1; m_done = 0; end
            end
        end
    endtask

    function automatic logic [21:0] dut_vec();
        return {op_code_w_reset, op_code_w_execute, test_number, busy, state, done_sticky,
                err_illegal, err_busy, err_timeout, aborted, cmd_count};
    endfunction

    function automatic logic [21:0] model_vec();
        return {m_mode == 1, m_mode == 2, 4'(m_tn), m_mode != 0, 2'(m_mode), m_done,
                m_ill, m_ebusy, m_eto, m_abort, 8'(m_cnt)};
    endfunction

    task automatic step(input bit wr, input logic [7:0] w, input bit d);
        cmd_wr = wr; cmd_word = w; test_done = d;
        @(posedge clk);
        if (reset_n) model_step(wr, w, d);
        #1;
        cmd_wr = 0; cmd_word = 8'h00; test_done = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        model_reset();
        #12;
        n_cmp++;
        if (dut_vec() !== 22'd0) begin
            n_bad++; $display("FAIL reset_outputs got=%h want=0", dut_vec());
        end
        reset_n = 1;
        step(0, 8'h00, 0);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++; $display("FAIL reset_idle got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_execute_done();
        step(1, 8'h32, 0);
        n_cmp++;
        if ({op_code_w_execute, test_number, busy, state} !== {1'b1, 4'd3, 1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL exec_start got=%b want=%b",
                     {op_code_w_execute, test_number, busy, state}, {1'b1, 4'd3, 1'b1, 2'd2});
        end
        for (int i = 0; i < 19; i++) step(0, 8'h00, 0);
        n_cmp++;
        if (op_code_w_execute !== 1'b1) begin
            n_bad++; $display("FAIL exec_held got=%b want=1", op_code_w_execute);
        end
        step(0, 8'h00, 1);
        n_cmp++;
        if ({op_code_w_execute, done_sticky, cmd_count} !== {1'b0, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL exec_done got=%b/%b/%0d want=0/1/1",
                     op_code_w_execute, done_sticky, cmd_count);
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++; $display("FAIL exec_done_model got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_cmd();
        int hi;
        int ex;
        step(1, 8'h01, 0);
        hi = op_code_w_reset ? 1 : 0;
        ex = 0;
        n_cmp++;
        if (test_number !== 4'd0) begin
            n_bad++; $display("FAIL rst_testnum got=%0d want=0", test_number);
        end
        for (int k = 1; k <= 10; k++) begin
            step(k == 1, 8'h12, 0);
            if (op_code_w_reset) hi++;
            if (op_code_w_execute) ex++;
        end
        n_cmp++;
        if (hi != RC) begin
            n_bad++; $display("FAIL rst_width got=%0d want=%0d", hi, RC);
        end
        n_cmp++;
        if ({err_busy, ex[0], cmd_count} !== {1'b1, 1'b0, 8'd2}) begin
            n_bad++;
            $display("FAIL rst_busy_reject got=%b/%0d/%0d want=1/0/2", err_busy, ex, cmd_count);
        end
    endtask

    task automatic test_illegal();
        int ex = 0;
        step(1, 8'h62, 0);
        if (op_code_w_execute) ex++;
        step(1, 8'h02, 0);
        if (op_code_w_execute) ex++;
        n_cmp++;
        if ({err_illegal, state, ex[0]} !== {1'b1, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL illegal_exec got=%b/%0d/%0d want=1/0/0", err_illegal, state, ex);
        end
        step(1, 8'h04, 0);
        n_cmp++;
        if (err_illegal !== 1'b0) begin
            n_bad++; $display("FAIL illegal_clear got=%b want=0", err_illegal);
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++; $display("FAIL illegal_model got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_timeout();
        int n;
        step(1, 8'h52, 0);
        n = op_code_w_execute ? 1 : 0;
        for (int i = 0; i < TO + 50; i++) begin
            if (!op_code_w_execute) break;
            step(0, 8'h00, 0);
            if (op_code_w_execute) n++;
        end
        n_cmp++;
        if (n != TO) begin
            n_bad++; $display("FAIL timeout_width got=%0d want=%0d", n, TO);
        end
        n_cmp++;
        if ({err_timeout, op_code_w_execute} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_flag got=%b/%b want=1/0", err_timeout, op_code_w_execute);
        end
        step(1, 8'h04, 0);
        step(1, 8'h52, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        n_cmp++;
        if ({done_sticky, err_timeout, op_code_w_execute} !== 3'b100) begin
            n_bad++;
            $display("FAIL timeout_vs_done got=%b want=100",
                     {done_sticky, err_timeout, op_code_w_execute});
        end
    endtask

    task automatic test_done_abort_reset();
        int ov0;
        step(1, 8'h12, 0);
        step(0, 8'h00, 0);
        step(1, 8'h03, 1);
        n_cmp++;
        if ({done_sticky, aborted, op_code_w_execute} !== 3'b100) begin
            n_bad++;
            $display("FAIL done_vs_abort got=%b want=100",
                     {done_sticky, aborted, op_code_w_execute});
        end
        ov0 = overlap;
        step(1, 8'h22, 0);
        step(0, 8'h00, 0);
        n_cmp++;
        if ({op_code_w_reset, op_code_w_execute} !== 2'b01) begin
            n_bad++;
            $display("FAIL pre_reset got=%b want=01", {op_code_w_reset, op_code_w_execute});
        end
        step(1, 8'h01, 0);
        n_cmp++;
        if ({op_code_w_reset, op_code_w_execute} !== 2'b10) begin
            n_bad++;
            $display("FAIL exec_to_reset got=%b want=10", {op_code_w_reset, op_code_w_execute});
        end
        for (int i = 0; i < RC + 2; i++) step(0, 8'h00, 0);
        n_cmp++;
        if (overlap != ov0) begin
            n_bad++; $display("FAIL overlap got=%0d want=%0d", overlap, ov0);
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++; $display("FAIL reset_seq_model got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_count_wrap();
        int n = 256 - m_cnt;
        for (int i = 0; i < n; i++) step(1, 8'h03, 0);
        n_cmp++;
        if (cmd_count !== 8'd0) begin
            n_bad++; $display("FAIL count_wrap got=%0d want=0", cmd_count);
        end
        step(1, 8'h42, 0);
        step(0, 8'h00, 0);
        #2;
        reset_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec() !== 22'd0) begin
            n_bad++; $display("FAIL async_reset got=%h want=0", dut_vec());
        end
        #3;
        reset_n = 1;
        step(0, 8'h00, 0);
    endtask

    task automatic test_random();
        logic [7:0] w;
        bit wr, d;
        for (int i = 0; i < 1500; i++) begin
            wr = ($urandom_range(0, 2) == 0);
            w = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 6))};
            d = ($urandom_range(0, 15) == 0);
            step(wr, w, d);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_execute_done();
        test_reset_cmd();
        test_illegal();
        test_timeout();
        test_done_abort_reset();
        test_count_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
